// File: rtl/riscv_pkg.sv
// Shared types and constants for the hazard unit.
package riscv_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_W  = 2'd1,
    FWD_M  = 2'd2
  } fwd_sel_e;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } hz_state_e;

endpackage

// File: rtl/riscv_hzrdu_scoreboard.sv
// Long-latency scoreboard: pending bit per register, outstanding count, sticky error.
module riscv_hzrdu_scoreboard #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LL_DEPTH = 2,
  localparam int unsigned CNT_W   = $clog2(LL_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              llop_e_i,
  input  logic [ADDR_W-1:0] rdaddr_e_i,
  input  logic              lldone_i,
  input  logic [ADDR_W-1:0] llrdaddr_i,
  input  logic [ADDR_W-1:0] rs1addr_d_i,
  input  logic [ADDR_W-1:0] rs2addr_d_i,
  output logic              raw_hazard_o,
  output logic [CNT_W-1:0]  llcount_o,
  output logic [CNT_W-1:0]  llcount_nxt_o,
  output logic              err_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             issue;

  assign issue = llop_e_i && (rdaddr_e_i != '0);

  // Next-state: completion is applied first so a same-register issue wins the bit.
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (lldone_i) begin
      if (pending_q[llrdaddr_i]) begin
        pending_d[llrdaddr_i] = 1'b0;
        cnt_d                 = cnt_d - CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end
    if (issue) begin
      pending_d[rdaddr_e_i] = 1'b1;
      cnt_d                 = cnt_d + CNT_W'(1);
    end
    pending_d[0] = 1'b0;
  end

  // State registers with synchronous reset discarding outstanding operations.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign raw_hazard_o  = pending_q[rs1addr_d_i] || pending_q[rs2addr_d_i];
  assign llcount_o     = cnt_q;
  assign llcount_nxt_o = cnt_d;
  assign err_o         = err_q;

endmodule

// File: rtl/riscv_hzrdu_sb.sv
// Hazard unit: forwarding, load-use/scoreboard/structural stalls, fence drain FSM.
module riscv_hzrdu_sb
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LL_DEPTH = 2
) (
  input  logic                             i_riscv_hzrdu_clk,
  input  logic                             i_riscv_hzrdu_rst,
  input  logic [ADDR_W-1:0]                i_riscv_hzrdu_rs1addr_d,
  input  logic [ADDR_W-1:0]                i_riscv_hzrdu_rs2addr_d,
  input  logic [ADDR_W-1:0]                i_riscv_hzrdu_rs1addr_e,
  input  logic [ADDR_W-1:0]                i_riscv_hzrdu_rs2addr_e,
  input  logic [ADDR_W-1:0]                i_riscv_hzrdu_rdaddr_e,
  input  logic [ADDR_W-1:0]                i_riscv_hzrdu_rdaddr_m,
  input  logic [ADDR_W-1:0]                i_riscv_hzrdu_rdaddr_w,
  input  logic                             i_riscv_hzrdu_regw_m,
  input  logic                             i_riscv_hzrdu_regw_w,
  input  logic [1:0]                       i_riscv_hzrdu_resultsrc_e,
  input  logic                             i_riscv_hzrdu_pcsrc,
  input  logic                             i_riscv_hzrdu_llop_d,
  input  logic                             i_riscv_hzrdu_llop_e,
  input  logic                             i_riscv_hzrdu_fence_d,
  input  logic                             i_riscv_hzrdu_lldone,
  input  logic [ADDR_W-1:0]                i_riscv_hzrdu_llrdaddr,
  output logic [1:0]                       o_riscv_hzrdu_fwda,
  output logic [1:0]                       o_riscv_hzrdu_fwdb,
  output logic                             o_riscv_hzrdu_stallpc,
  output logic                             o_riscv_hzrdu_stallfd,
  output logic                             o_riscv_hzrdu_flushfd,
  output logic                             o_riscv_hzrdu_flushde,
  output logic [$clog2(LL_DEPTH+1)-1:0]    o_riscv_hzrdu_llcount,
  output logic                             o_riscv_hzrdu_err
);

  localparam int unsigned CNT_W = $clog2(LL_DEPTH + 1);

  fwd_sel_e   fwda, fwdb;
  hz_state_e  state_q, state_d;
  logic [CNT_W-1:0] llcount, llcount_nxt;
  logic       raw_hazard, lu_hazard, st_hazard, fence_wait, stall;

  riscv_hzrdu_scoreboard #(
    .ADDR_W   (ADDR_W),
    .LL_DEPTH (LL_DEPTH)
  ) u_sb (
    .clk_i         (i_riscv_hzrdu_clk),
    .rst_i         (i_riscv_hzrdu_rst),
    .llop_e_i      (i_riscv_hzrdu_llop_e),
    .rdaddr_e_i    (i_riscv_hzrdu_rdaddr_e),
    .lldone_i      (i_riscv_hzrdu_lldone),
    .llrdaddr_i    (i_riscv_hzrdu_llrdaddr),
    .rs1addr_d_i   (i_riscv_hzrdu_rs1addr_d),
    .rs2addr_d_i   (i_riscv_hzrdu_rs2addr_d),
    .raw_hazard_o  (raw_hazard),
    .llcount_o     (llcount),
    .llcount_nxt_o (llcount_nxt),
    .err_o         (o_riscv_hzrdu_err)
  );

  // Forwarding selects; the later M assignment gives M priority over W.
  always_comb begin
    fwda = FWD_RF;
    fwdb = FWD_RF;
    if (i_riscv_hzrdu_regw_w && (i_riscv_hzrdu_rs1addr_e != '0) &&
        (i_riscv_hzrdu_rs1addr_e == i_riscv_hzrdu_rdaddr_w)) fwda = FWD_W;
    if (i_riscv_hzrdu_regw_m && (i_riscv_hzrdu_rs1addr_e != '0) &&
        (i_riscv_hzrdu_rs1addr_e == i_riscv_hzrdu_rdaddr_m)) fwda = FWD_M;
    if (i_riscv_hzrdu_regw_w && (i_riscv_hzrdu_rs2addr_e != '0) &&
        (i_riscv_hzrdu_rs2addr_e == i_riscv_hzrdu_rdaddr_w)) fwdb = FWD_W;
    if (i_riscv_hzrdu_regw_m && (i_riscv_hzrdu_rs2addr_e != '0) &&
        (i_riscv_hzrdu_rs2addr_e == i_riscv_hzrdu_rdaddr_m)) fwdb = FWD_M;
  end

  assign lu_hazard = (i_riscv_hzrdu_resultsrc_e == RESULTSRC_LOAD) &&
                     (i_riscv_hzrdu_rdaddr_e != '0) &&
                     ((i_riscv_hzrdu_rdaddr_e == i_riscv_hzrdu_rs1addr_d) ||
                      (i_riscv_hzrdu_rdaddr_e == i_riscv_hzrdu_rs2addr_d));
  assign st_hazard  = i_riscv_hzrdu_llop_d && (llcount == CNT_W'(LL_DEPTH));
  assign fence_wait = i_riscv_hzrdu_fence_d && (llcount != '0);

  // Drain FSM next state; a taken branch always returns to RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (fence_wait && !i_riscv_hzrdu_pcsrc) state_d = ST_DRAIN;
      ST_DRAIN: if (i_riscv_hzrdu_pcsrc || (llcount_nxt == '0)) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge i_riscv_hzrdu_clk) begin
    if (i_riscv_hzrdu_rst) state_q <= ST_RUN;
    else                   state_q <= state_d;
  end

  assign stall = lu_hazard || raw_hazard || st_hazard || (state_q == ST_DRAIN) ||
                 ((state_q == ST_RUN) && fence_wait);

  assign o_riscv_hzrdu_fwda    = fwda;
  assign o_riscv_hzrdu_fwdb    = fwdb;
  assign o_riscv_hzrdu_stallpc = stall && !i_riscv_hzrdu_pcsrc;
  assign o_riscv_hzrdu_stallfd = stall && !i_riscv_hzrdu_pcsrc;
  assign o_riscv_hzrdu_flushfd = i_riscv_hzrdu_pcsrc;
  assign o_riscv_hzrdu_flushde = stall || i_riscv_hzrdu_pcsrc;
  assign o_riscv_hzrdu_llcount = llcount;

endmodule

// File: doc/riscv_hzrdu_sb.md
RISCV_HZRDU_SB -- requirements
Module: riscv_hzrdu_sb

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width; register file depth is 2**ADDR_W.
REQ-002 Parameter LL_DEPTH, default 2, maximum outstanding long-latency (mul/div) operations.
REQ-003 i_riscv_hzrdu_clk  in  1  single clock; every register SHALL update on its rising edge.
REQ-004 i_riscv_hzrdu_rst  in  1  reset, synchronous and active-high.
REQ-005 i_riscv_hzrdu_rs1addr_d, i_riscv_hzrdu_rs2addr_d  in  ADDR_W each  decode-stage source addresses.
REQ-006 i_riscv_hzrdu_rs1addr_e, i_riscv_hzrdu_rs2addr_e, i_riscv_hzrdu_rdaddr_e  in  ADDR_W each  execute-stage source and destination addresses.
REQ-007 i_riscv_hzrdu_rdaddr_m, i_riscv_hzrdu_rdaddr_w  in  ADDR_W each  memory- and writeback-stage destination addresses.
REQ-008 i_riscv_hzrdu_regw_m, i_riscv_hzrdu_regw_w  in  1 each  register-write enables for M and W.
REQ-009 i_riscv_hzrdu_resultsrc_e  in  2  execute result source; 2'b10 means load.
REQ-010 i_riscv_hzrdu_pcsrc  in  1  taken branch or jump, resolved in E.
REQ-011 i_riscv_hzrdu_llop_d, i_riscv_hzrdu_llop_e  in  1 each  long-latency operation present in D or issuing from E.
REQ-012 i_riscv_hzrdu_fence_d  in  1  fence or CSR instruction in D that requires drain.
REQ-013 i_riscv_hzrdu_lldone, i_riscv_hzrdu_llrdaddr  in  1 and ADDR_W  long-latency unit completion pulse and its destination register.
REQ-014 o_riscv_hzrdu_fwda, o_riscv_hzrdu_fwdb  out  2 each  forward select: 0 register file, 1 from W, 2 from M.
REQ-015 o_riscv_hzrdu_stallpc, o_riscv_hzrdu_stallfd, o_riscv_hzrdu_flushfd, o_riscv_hzrdu_flushde  out  1 each  pipeline control outputs.
REQ-016 o_riscv_hzrdu_llcount  out  $clog2(LL_DEPTH+1)  number of outstanding long-latency operations.
REQ-017 o_riscv_hzrdu_err  out  1  sticky flag for completion of a register that is not pending.

Function
REQ-018 fwda SHALL be 2 when rs1addr_e==rdaddr_m, regw_m=1 and rs1addr_e!=0; otherwise 1 when the same conditions hold against W; otherwise 0. M has priority over W. fwdb SHALL follow the same rule using rs2addr_e.
REQ-019 A load-use hazard exists when resultsrc_e==2'b10, rdaddr_e!=0, and rdaddr_e equals rs1addr_d or rs2addr_d.
REQ-020 The scoreboard SHALL hold 2**ADDR_W pending bits; bit 0 SHALL always read 0.
REQ-021 On a rising edge with llop_e=1 and rdaddr_e!=0, pending[rdaddr_e] SHALL be set and llcount incremented.
REQ-022 On a rising edge with lldone=1 and pending[llrdaddr]=1, pending[llrdaddr] SHALL be cleared and llcount decremented.
REQ-023 If lldone=1 while pending[llrdaddr]=0, the completion SHALL be ignored, llcount SHALL stay unchanged, and err SHALL be set.
REQ-024 If issue and completion occur in the same cycle, llcount SHALL stay unchanged; if both target the same register, the set SHALL win.
REQ-025 A scoreboard hazard exists when the pending bit for rs1addr_d or rs2addr_d is 1 (RAW).
REQ-026 A structural hazard exists when llop_d=1 and llcount==LL_DEPTH.
REQ-027 The FSM SHALL have two states, RUN and DRAIN.
REQ-028 In RUN, if fence_d=1, llcount!=0 and pcsrc=0, the FSM SHALL move to DRAIN on the next edge.
REQ-029 The FSM SHALL leave DRAIN for RUN on the edge where the next llcount is 0, or on any edge with pcsrc=1.
REQ-030 stall = load-use hazard OR scoreboard hazard OR structural hazard OR (state==DRAIN) OR (RUN AND fence_d AND llcount!=0).
REQ-031 stallpc and stallfd SHALL equal stall AND NOT pcsrc; a taken branch overrides all stalls.
REQ-032 flushfd SHALL equal pcsrc; flushde SHALL equal stall OR pcsrc.
REQ-033 All outputs except llcount, err and the FSM state SHALL be combinational, with zero-cycle latency.

Reset
REQ-034 While rst=1 at a clock edge, all pending bits, llcount and err SHALL clear and the FSM SHALL enter RUN.
REQ-035 During and after reset with idle inputs, fwda, fwdb and all stall and flush outputs SHALL be 0.
REQ-036 A reset applied while long-latency operations are outstanding SHALL discard them; completions arriving after reset SHALL set err.

Structure
REQ-037 The shared package riscv_pkg SHALL hold the fwd-select enumeration (FWD_RF=0, FWD_W=1, FWD_M=2), the RESULTSRC_LOAD constant, and the FSM state typedef.
REQ-038 The scoreboard SHALL be one sub-module, riscv_hzrdu_scoreboard, owning the pending bits, llcount and err.

Verification
REQ-039 rs1addr_e=5, rdaddr_m=5, regw_m=1, rdaddr_w=5, regw_w=1 -> fwda=2; with rdaddr_m=0 -> fwda=1; with rs1addr_e=0 -> fwda=0.
REQ-040 resultsrc_e=2'b10, rdaddr_e=7, rs2addr_d=7 -> stallpc=stallfd=flushde=1 for one cycle; with rdaddr_e=0 -> no stall.
REQ-041 Issue a long-latency op to x9, then rs1addr_d=9 -> stall every cycle until lldone with llrdaddr=9; stall drops the same cycle pending clears.
REQ-042 LL_DEPTH=2: two issues, then llop_d=1 -> stall; lldone plus a new llop_e in the same cycle -> llcount stays 2.
REQ-043 fence_d with llcount=1 -> DRAIN and stall; pcsrc=1 mid-drain -> stall=0, flushfd=flushde=1, state RUN next cycle.
REQ-044 lldone for a non-pending x3 -> err=1 and sticky; rst=1 -> err=0, llcount=0, state RUN.
